// File: rtl/ahb_pkg.sv
// Shared AHB encodings and burst helpers used by the arbiter slice.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  // Beats in a burst; 0 marks the undefined-length INCR burst.
  function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
    logic [4:0] beats;
    case (hburst)
      HBURST_SINGLE:               beats = 5'd1;
      HBURST_INCR:                 beats = 5'd0;
      HBURST_WRAP4, HBURST_INCR4:  beats = 5'd4;
      HBURST_WRAP8, HBURST_INCR8:  beats = 5'd8;
      default:                     beats = 5'd16;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// Arbiter-facing AHB signal bundle.
// Handshake: a beat is transferred on a rising edge where HREADY=1 (ready)
// and HTRANS is NONSEQ or SEQ (valid); with HREADY=0 every input is
// ignored and all arbiter state holds. dbg_* expose the internal beat
// counter and round-robin pointer for observation.
interface ahb_arbiter_if #(
  parameter int NO_OF_MASTERS = 4,
  parameter int MW            = $clog2(NO_OF_MASTERS)
) ();
  import ahb_pkg::*;

  logic [NO_OF_MASTERS-1:0] HBUSREQ;
  logic [NO_OF_MASTERS-1:0] HLOCK;
  logic [1:0]               HTRANS;
  logic [2:0]               HBURST;
  logic                     HREADY;
  logic [NO_OF_MASTERS-1:0] HGRANT;
  logic [MW-1:0]            HMASTER;
  logic [MW-1:0]            HMASTER_D;
  logic                     HMASTLOCK;
  logic [4:0]               dbg_remaining;
  logic [MW-1:0]            dbg_last_winner;

  // Bus side: masters / interconnect driving requests and transfer info.
  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    input  HGRANT, HMASTER, HMASTER_D, HMASTLOCK, dbg_remaining, dbg_last_winner
  );

  // Arbiter side.
  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    output HGRANT, HMASTER, HMASTER_D, HMASTLOCK, dbg_remaining, dbg_last_winner
  );

endinterface

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin select: first requester above last_winner.
module ahb_rr_picker #(
  parameter int NO_OF_MASTERS = 4,
  parameter int MW            = $clog2(NO_OF_MASTERS)
) (
  input  logic [NO_OF_MASTERS-1:0] req,
  input  logic [MW-1:0]            last_winner,
  output logic                     valid,
  output logic [MW-1:0]            winner,
  output logic [NO_OF_MASTERS-1:0] winner_onehot
);

  // Scan last_winner+1 .. last_winner+N (mod N); last_winner itself is last.
  always_comb begin
    int idx;
    logic [MW-1:0] idx_w;
    valid         = 1'b0;
    winner        = '0;
    winner_onehot = '0;
    idx           = 0;
    idx_w         = '0;
    for (int off = 1; off <= NO_OF_MASTERS; off++) begin
      idx   = (int'(last_winner) + off) % NO_OF_MASTERS;
      idx_w = MW'(idx);
      if (!valid && req[idx_w]) begin
        valid                = 1'b1;
        winner               = idx_w;
        winner_onehot[idx_w] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with burst, INCR and locked-sequence grant hold.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NO_OF_MASTERS = 4,
  parameter int MW            = $clog2(NO_OF_MASTERS)
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  ahb_arbiter_if.slave bus
);

  logic [4:0]               remaining;
  logic [4:0]               remaining_next;
  logic [4:0]               beats;
  logic [MW-1:0]            last_winner;
  logic [NO_OF_MASTERS-1:0] hgrant;
  logic [MW-1:0]            hmaster;
  logic [MW-1:0]            hmaster_d;
  logic                     hmastlock;
  logic                     incr_hold;
  logic                     hold;
  logic                     arbitrate;
  logic [NO_OF_MASTERS-1:0] others;
  logic [NO_OF_MASTERS-1:0] pick_req;
  logic                     pick_valid;
  logic [MW-1:0]            pick_idx;
  logic [NO_OF_MASTERS-1:0] pick_onehot;
  logic [MW-1:0]            winner;
  logic [NO_OF_MASTERS-1:0] winner_onehot;

  // Beat counter update; it only moves on edges with HREADY=1.
  always_comb begin
    beats          = burst_beats(bus.HBURST);
    remaining_next = remaining;
    if (bus.HREADY) begin
      case (bus.HTRANS)
        HTRANS_NONSEQ: remaining_next = (beats > 5'd1) ? beats - 5'd1 : 5'd0;
        HTRANS_SEQ:    remaining_next = (remaining != 5'd0) ? remaining - 5'd1 : 5'd0;
        HTRANS_IDLE:   remaining_next = 5'd0;
        default:       remaining_next = remaining;
      endcase
    end
  end

  // Hold decision on post-update counter; owner re-wins only when alone.
  always_comb begin
    incr_hold     = (bus.HBURST == HBURST_INCR) && (bus.HTRANS != HTRANS_IDLE) &&
                    bus.HBUSREQ[hmaster];
    hold          = (remaining_next != 5'd0) || incr_hold || bus.HLOCK[hmaster];
    arbitrate     = bus.HREADY && !hold;
    others        = bus.HBUSREQ & ~hgrant;
    pick_req      = (others != '0) ? others : bus.HBUSREQ;
    winner        = pick_valid ? pick_idx : '0;
    winner_onehot = pick_valid ? pick_onehot : NO_OF_MASTERS'(1);
  end

  ahb_rr_picker #(
    .NO_OF_MASTERS(NO_OF_MASTERS),
    .MW           (MW)
  ) u_picker (
    .req          (pick_req),
    .last_winner  (last_winner),
    .valid        (pick_valid),
    .winner       (pick_idx),
    .winner_onehot(pick_onehot)
  );

  // Grant, owner indices, lock flag and counter registers.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      remaining   <= 5'd0;
      last_winner <= MW'(NO_OF_MASTERS - 1);
      hgrant      <= NO_OF_MASTERS'(1);
      hmaster     <= '0;
      hmaster_d   <= '0;
      hmastlock   <= 1'b0;
    end else begin
      remaining <= remaining_next;
      if (bus.HREADY) begin
        hmaster_d <= hmaster;
      end
      if (arbitrate) begin
        hgrant      <= winner_onehot;
        hmaster     <= winner;
        last_winner <= winner;
        hmastlock   <= bus.HLOCK[winner];
      end
    end
  end

  assign bus.HGRANT          = hgrant;
  assign bus.HMASTER         = hmaster;
  assign bus.HMASTER_D       = hmaster_d;
  assign bus.HMASTLOCK       = hmastlock;
  assign bus.dbg_remaining   = remaining;
  assign bus.dbg_last_winner = last_winner;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter with hand-computed expectations.
module tb_ahb_arbiter;
  import ahb_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ahb_arbiter_if #(.NO_OF_MASTERS(4)) bus ();

  ahb_arbiter #(.NO_OF_MASTERS(4)) dut (
    .HCLK   (clk),
    .HRESETn(rst_n),
    .bus    (bus)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] lock,
                       input logic [1:0] trans, input logic [2:0] burst,
                       input logic ready);
    bus.HBUSREQ = req;
    bus.HLOCK   = lock;
    bus.HTRANS  = trans;
    bus.HBURST  = burst;
    bus.HREADY  = ready;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(4'b0000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);

    // Reset values
    tick();
    tick();
    chk("rst_hgrant", int'(bus.HGRANT), 1);
    chk("rst_hmaster", int'(bus.HMASTER), 0);
    chk("rst_hmaster_d", int'(bus.HMASTER_D), 0);
    chk("rst_hmastlock", int'(bus.HMASTLOCK), 0);
    chk("rst_remaining", int'(bus.dbg_remaining), 0);
    chk("rst_last_winner", int'(bus.dbg_last_winner), 3);

    // Idle after release: park on master 0
    rst_n = 1'b1;
    tick();
    chk("park_hgrant", int'(bus.HGRANT), 1);
    chk("park_last_winner", int'(bus.dbg_last_winner), 0);

    // Master 1 requests: granted after one edge
    drive(4'b0010, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
    tick();
    chk("req1_hgrant", int'(bus.HGRANT), 2);
    chk("req1_hmaster", int'(bus.HMASTER), 1);
    chk("req1_hmaster_d", int'(bus.HMASTER_D), 0);

    // Master 1 INCR4 with master 2 waiting
    drive(4'b0110, 4'b0000, HTRANS_NONSEQ, HBURST_INCR4, 1'b1);
    tick();
    chk("incr4_b1_hgrant", int'(bus.HGRANT), 2);
    chk("incr4_b1_remaining", int'(bus.dbg_remaining), 3);
    chk("incr4_b1_hmaster_d", int'(bus.HMASTER_D), 1);
    drive(4'b0110, 4'b0000, HTRANS_SEQ, HBURST_INCR4, 1'b1);
    tick();
    chk("incr4_b2_hgrant", int'(bus.HGRANT), 2);
    chk("incr4_b2_remaining", int'(bus.dbg_remaining), 2);
    tick();
    chk("incr4_b3_hgrant", int'(bus.HGRANT), 2);
    chk("incr4_b3_remaining", int'(bus.dbg_remaining), 1);
    tick();
    chk("incr4_b4_hgrant", int'(bus.HGRANT), 4);
    chk("incr4_b4_hmaster", int'(bus.HMASTER), 2);
    chk("incr4_b4_hmaster_d", int'(bus.HMASTER_D), 1);
    chk("incr4_b4_remaining", int'(bus.dbg_remaining), 0);

    // Nobody requests: park on master 0
    drive(4'b0000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
    tick();
    chk("park2_hgrant", int'(bus.HGRANT), 1);
    chk("park2_hmaster_d", int'(bus.HMASTER_D), 2);

    // All four request SINGLE: 0 (parked) then 1,2,3,0
    drive(4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
    tick();
    chk("rr_1", int'(bus.HMASTER), 1);
    tick();
    chk("rr_2", int'(bus.HMASTER), 2);
    chk("rr_2_hmaster_d", int'(bus.HMASTER_D), 1);
    tick();
    chk("rr_3", int'(bus.HMASTER), 3);
    tick();
    chk("rr_0", int'(bus.HMASTER), 0);
    chk("rr_0_hgrant", int'(bus.HGRANT), 1);

    // Master 0 WRAP8, master 1 waiting, 2-cycle stall on beat 3
    drive(4'b0011, 4'b0000, HTRANS_NONSEQ, HBURST_WRAP8, 1'b1);
    tick();
    chk("wrap8_b1_remaining", int'(bus.dbg_remaining), 7);
    drive(4'b0011, 4'b0000, HTRANS_SEQ, HBURST_WRAP8, 1'b1);
    tick();
    chk("wrap8_b2_remaining", int'(bus.dbg_remaining), 6);
    drive(4'b0011, 4'b0000, HTRANS_SEQ, HBURST_WRAP8, 1'b0);
    tick();
    chk("wrap8_stall1_remaining", int'(bus.dbg_remaining), 6);
    chk("wrap8_stall1_hgrant", int'(bus.HGRANT), 1);
    tick();
    chk("wrap8_stall2_remaining", int'(bus.dbg_remaining), 6);
    chk("wrap8_stall2_hgrant", int'(bus.HGRANT), 1);
    drive(4'b0011, 4'b0000, HTRANS_SEQ, HBURST_WRAP8, 1'b1);
    tick();
    chk("wrap8_b3_remaining", int'(bus.dbg_remaining), 5);
    tick();
    tick();
    tick();
    tick();
    chk("wrap8_b7_remaining", int'(bus.dbg_remaining), 1);
    chk("wrap8_b7_hgrant", int'(bus.HGRANT), 1);
    tick();
    chk("wrap8_b8_hgrant", int'(bus.HGRANT), 2);
    chk("wrap8_b8_hmaster", int'(bus.HMASTER), 1);
    chk("wrap8_b8_hmaster_d", int'(bus.HMASTER_D), 0);

    // Master 3 locked sequence while master 0 waits
    drive(4'b1000, 4'b1000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
    tick();
    chk("lock_grant", int'(bus.HGRANT), 8);
    chk("lock_hmastlock", int'(bus.HMASTLOCK), 1);
    drive(4'b1001, 4'b1000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
    tick();
    chk("lock_hold1", int'(bus.HGRANT), 8);
    tick();
    chk("lock_hold2", int'(bus.HGRANT), 8);
    chk("lock_hold2_hmastlock", int'(bus.HMASTLOCK), 1);
    drive(4'b0001, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
    tick();
    chk("unlock_hgrant", int'(bus.HGRANT), 1);
    chk("unlock_hmastlock", int'(bus.HMASTLOCK), 0);

    // Master 2 INCR16 aborted by IDLE after 5 beats, master 0 waiting
    drive(4'b0100, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
    tick();
    chk("incr16_grant", int'(bus.HMASTER), 2);
    drive(4'b0101, 4'b0000, HTRANS_NONSEQ, HBURST_INCR16, 1'b1);
    tick();
    chk("incr16_b1_remaining", int'(bus.dbg_remaining), 15);
    drive(4'b0101, 4'b0000, HTRANS_SEQ, HBURST_INCR16, 1'b1);
    tick();
    tick();
    tick();
    tick();
    chk("incr16_b5_remaining", int'(bus.dbg_remaining), 11);
    chk("incr16_b5_hgrant", int'(bus.HGRANT), 4);
    drive(4'b0101, 4'b0000, HTRANS_IDLE, HBURST_INCR16, 1'b1);
    tick();
    chk("abort_remaining", int'(bus.dbg_remaining), 0);
    chk("abort_hgrant", int'(bus.HGRANT), 1);
    chk("abort_hmaster_d", int'(bus.HMASTER_D), 2);

    // HREADY low freezes the data-phase index
    drive(4'b0101, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    tick();
    chk("stall_hmaster_d", int'(bus.HMASTER_D), 2);

    // Undefined-length INCR holds while requested
    drive(4'b0011, 4'b0000, HTRANS_NONSEQ, HBURST_INCR, 1'b1);
    tick();
    chk("incr_hold_hgrant", int'(bus.HGRANT), 1);
    drive(4'b0010, 4'b0000, HTRANS_SEQ, HBURST_INCR, 1'b1);
    tick();
    chk("incr_release_hgrant", int'(bus.HGRANT), 2);

    // Reset mid-burst
    drive(4'b0010, 4'b0000, HTRANS_NONSEQ, HBURST_INCR8, 1'b1);
    tick();
    chk("midburst_remaining", int'(bus.dbg_remaining), 7);
    rst_n = 1'b0;
    tick();
    chk("rst2_hgrant", int'(bus.HGRANT), 1);
    chk("rst2_hmaster", int'(bus.HMASTER), 0);
    chk("rst2_remaining", int'(bus.dbg_remaining), 0);
    chk("rst2_last_winner", int'(bus.dbg_last_winner), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Multi-master bus arbiter for the AHB interconnect that feeds the `ahb_slave` memory slaves. It grants one master at a time using round-robin priority, holds the grant across fixed-length bursts, undefined-length INCR bursts and locked sequences, and drives the address-phase and data-phase master indices that steer the interconnect's master-side multiplexers. It is fully synchronous to the bus clock.

## Interface
Parameters:
- NO_OF_MASTERS, 4 — number of requesting masters; must be ≥2.
- MW, $clog2(NO_OF_MASTERS) — master index width (derived).

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  reset; one clock, reset is synchronous and active-low.
- HBUSREQ  in  NO_OF_MASTERS  per-master bus request.
- HLOCK  in  NO_OF_MASTERS  per-master locked-sequence request.
- HTRANS  in  2  muxed HTRANS of the current address-phase owner.
- HBURST  in  3  muxed HBURST of the current address-phase owner.
- HREADY  in  1  bus-wide transfer-complete.
- HGRANT  out  NO_OF_MASTERS  one-hot grant.
- HMASTER  out  MW  address-phase owner index.
- HMASTER_D  out  MW  data-phase owner index.
- HMASTLOCK  out  1  current address phase is locked.

## Operation
- Encodings: HTRANS IDLE=00, BUSY=01, NONSEQ=10, SEQ=11. HBURST SINGLE=000, INCR=001, WRAP4=010, INCR4=011, WRAP8=100, INCR8=101, WRAP16=110, INCR16=111.
- Accepted beat: HREADY=1 and HTRANS ∈ {NONSEQ, SEQ}.
- Beat counter `remaining` (5 bits):
  - Accepted NONSEQ with a fixed burst → load beats−1 (3, 7 or 15).
  - Accepted NONSEQ with SINGLE or INCR → load 0.
  - Accepted SEQ → decrement, saturating at 0.
  - Accepted IDLE while HREADY=1 → clear to 0 (early termination).
  - BUSY → hold.
- Hold condition, evaluated with post-update values. The grant is kept if any of the following holds:
  - `remaining` > 0.
  - Owner issued INCR NONSEQ/SEQ/BUSY this cycle and HBUSREQ[owner]=1.
  - HLOCK[owner]=1.
- Arbitration occurs only on an edge with HREADY=1 and hold false.
  - Winner: first requester scanning upward from last_winner+1, modulo NO_OF_MASTERS.
  - No requester: park on master 0.
  - The owner may re-win only if it is the sole requester.
- HGRANT, HMASTER and last_winner update together at the arbitration edge.
- HMASTER_D ← HMASTER on every edge with HREADY=1; it holds while HREADY=0.
- HMASTLOCK ← HLOCK[winner] at each grant update; it holds otherwise.

## Timing
- Reset values: HGRANT=0…01, HMASTER=0, HMASTER_D=0, HMASTLOCK=0, remaining=0, last_winner=NO_OF_MASTERS−1.
- Grant latency: a request is seen at edge N. If the bus is free and HREADY=1, HGRANT is asserted after edge N, and the new master drives its address phase in cycle N+1.
- Final beat of a fixed burst: the handover edge is the edge accepting the last SEQ. HMASTER changes at that edge; HMASTER_D shows the old owner for that beat's data phase.
- HREADY=0 freezes all state: grants, counter and HMASTER_D.
- Owner drops HBUSREQ mid fixed burst: the grant is still held until `remaining` reaches 0.
- Simultaneous new NONSEQ and request change: counter load takes precedence, so hold applies.
- Reset asserted mid-burst: all state returns to reset values at the next edge.

## Structure
- Shared package `ahb_pkg`:
  - HTRANS and HBURST localparams.
  - Function `burst_beats(hburst)` returning 1/4/8/16, with 0 meaning undefined length for INCR.
- One sub-module `ahb_rr_picker`: combinational round-robin select.
  - Inputs: request vector and last_winner.
  - Outputs: valid, winner index and one-hot.
  - The arbiter instantiates it once.

## Test plan
- Reset then idle, no requests → HGRANT=0001, HMASTER=0 parked; on release, HBUSREQ=0010 → HGRANT=0010 one edge later.
- Masters 1 and 2 request; master 1 issues INCR4 (NONSEQ + 3 SEQ) → grant held 4 accepted beats, moves to 2 at the 4th; HMASTER_D=1 during last data phase.
- All four requesting SINGLE back-to-back → grant order 0,1,2,3,0; each holds one beat.
- Master 0 WRAP8 with HREADY=0 inserted for 2 cycles on beat 3 → grant and counter frozen, handover after 8th accepted beat.
- Master 3 HLOCK=1 with SINGLE transfers and master 0 requesting → HMASTLOCK=1, grant held until HLOCK drops, then master 0 granted.
- Master 2 INCR16 aborted by IDLE after 5 beats → remaining clears, re-arbitration at that edge.
